// File: rtl/cam_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_pkg                                                              |
// | Shared types and widths for the camera capture path.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cam_pkg;

    localparam int PIX_W = 16;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_FRAME  = 2'd2
    } cam_state_t;

    typedef struct packed {
        logic             sof;
        logic [Y_W-1:0]   y;
        logic [X_W-1:0]   x;
        logic [PIX_W-1:0] data;
    } cam_word_t;

endpackage
`default_nettype wire

// File: rtl/cam_pix_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_pix_fifo                                                         |
// | Synchronous show-ahead FIFO; writes into a full FIFO are discarded.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cam_pix_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_wr;
    logic             w_do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_wr = i_wr_en & ~o_full;
    assign w_do_rd = i_rd_en & ~o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[c_aw-1:0]] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/cam_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_capture                                                          |
// | Oversamples the camera bus, packs byte pairs into tagged RGB565 px.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int BYTE_SWAP  = 0
) (
    input  logic             clk100,
    input  logic             reset,
    input  logic             cam_pclk,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    input  logic             enable,
    input  logic             clear,
    output logic [PIX_W-1:0] pix_data,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic             pix_sof,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             frame_done,
    output logic [7:0]       frame_count,
    output logic             overflow,
    output logic             fmt_err
);

    localparam logic [X_W-1:0] c_h_max = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] c_v_max = Y_W'(V_ACTIVE);

    logic [2:0]     r_pclk_sync;
    logic [1:0]     r_vsync_sync;
    logic [1:0]     r_href_sync;
    logic [7:0]     r_data_s1, r_data_s2;
    logic           r_rise;
    logic           r_vsync_smp, r_href_smp, r_href_prev;
    logic [7:0]     r_data_smp;
    cam_state_t     r_state, w_state_nxt;
    logic           w_frame_start, w_frame_end;
    logic           r_phase;
    logic [7:0]     r_byte0;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           r_wr_en;
    cam_word_t      r_wr_word;
    logic           r_frame_done;
    logic [7:0]     r_frame_count;
    logic           r_overflow, r_fmt_err;
    logic           w_pclk_rise, w_active, w_in_range, w_form, w_line_end;
    logic           w_fmt_set, w_ovf_set;
    logic [15:0]    w_pixel;
    logic           w_fifo_full, w_fifo_empty, w_rd_en;
    cam_word_t      w_rd_word, w_out;

    assign w_pclk_rise = r_pclk_sync[1] & ~r_pclk_sync[2];

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_pclk_sync  <= '0;
            r_vsync_sync <= '0;
            r_href_sync  <= '0;
            r_data_s1    <= '0;
            r_data_s2    <= '0;
            r_rise       <= 1'b0;
            r_vsync_smp  <= 1'b0;
            r_href_smp   <= 1'b0;
            r_href_prev  <= 1'b0;
            r_data_smp   <= '0;
        end else begin
            r_pclk_sync  <= {r_pclk_sync[1:0], cam_pclk};
            r_vsync_sync <= {r_vsync_sync[0], cam_vsync};
            r_href_sync  <= {r_href_sync[0], cam_href};
            r_data_s1    <= cam_data;
            r_data_s2    <= r_data_s1;
            r_rise       <= w_pclk_rise;
            if (w_pclk_rise) begin
                r_vsync_smp <= r_vsync_sync[1];
                r_href_smp  <= r_href_sync[1];
                r_href_prev <= r_href_smp;
                r_data_smp  <= r_data_s2;
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        if (r_rise) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_vsync_smp) w_state_nxt = ST_VBLANK;
                end
                ST_VBLANK: begin
                    if (!r_vsync_smp) begin
                        if (enable) begin
                            w_state_nxt   = ST_FRAME;
                            w_frame_start = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_FRAME: begin
                    if (r_vsync_smp) begin
                        w_state_nxt = ST_VBLANK;
                        w_frame_end = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_active   = r_rise && (r_state == ST_FRAME) && !r_vsync_smp;
    assign w_in_range = (r_x < c_h_max) && (r_y < c_v_max);
    assign w_form     = w_active && r_href_smp && r_phase;
    assign w_line_end = w_active && !r_href_smp && r_href_prev;
    assign w_pixel    = (BYTE_SWAP != 0) ? {r_data_smp, r_byte0} : {r_byte0, r_data_smp};
    assign w_fmt_set  = (w_form && !w_in_range) || (w_line_end && r_phase);
    assign w_ovf_set  = r_wr_en && w_fifo_full;

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_phase       <= 1'b0;
            r_byte0       <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_wr_en       <= 1'b0;
            r_wr_word     <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
            r_fmt_err     <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= w_frame_end;
            if (w_frame_end) r_frame_count <= r_frame_count + 1'b1;
            // A set in the same cycle as clear must survive.
            r_fmt_err  <= w_fmt_set | (r_fmt_err & ~clear);
            r_overflow <= w_ovf_set | (r_overflow & ~clear);
            if (w_frame_start) begin
                r_x     <= '0;
                r_y     <= '0;
                r_phase <= 1'b0;
            end else if (w_active && r_href_smp) begin
                if (!r_phase) begin
                    r_byte0 <= r_data_smp;
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    if (w_in_range) begin
                        r_wr_en        <= 1'b1;
                        r_wr_word.sof  <= (r_x == '0) && (r_y == '0);
                        r_wr_word.y    <= r_y;
                        r_wr_word.x    <= r_x;
                        r_wr_word.data <= w_pixel;
                    end
                    // x advances even when the FIFO drops this pixel.
                    if (r_x < c_h_max) r_x <= r_x + 1'b1;
                end
            end else if (w_line_end) begin
                r_x     <= '0;
                r_phase <= 1'b0;
                if (r_y < c_v_max) r_y <= r_y + 1'b1;
            end
        end
    end

    cam_pix_fifo #(
        .WIDTH($bits(cam_word_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk100),
        .rst      (reset),
        .i_wr_en  (r_wr_en),
        .i_wr_data(r_wr_word),
        .i_rd_en  (w_rd_en),
        .o_rd_data(w_rd_word),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty)
    );

    assign pix_valid   = ~w_fifo_empty;
    assign w_rd_en     = pix_valid & pix_ready;
    // Unwritten FIFO storage is never exposed on the stream.
    assign w_out       = pix_valid ? w_rd_word : '0;
    assign pix_data    = w_out.data;
    assign pix_x       = w_out.x;
    assign pix_y       = w_out.y;
    assign pix_sof     = w_out.sof;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign overflow    = r_overflow;
    assign fmt_err     = r_fmt_err;

endmodule
`default_nettype wire

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Receive side of the camera interface: the camera is clocked by camclk and returns PCLK, VSYNC, HREF and an 8-bit data bus.
- This block oversamples those signals in the clk100 domain and packs byte pairs into 16-bit RGB565 pixels.
- It tags each pixel with x/y coordinates and start-of-frame, then delivers it over a valid/ready stream to the frame-buffer writer.
- Requirement: camera PCLK at most clk100/4, i.e. 25 MHz max (20 MHz nominal).

Parameters:
- H_ACTIVE, 640, pixels per line; pixels beyond this are dropped.
- V_ACTIVE, 480, lines per frame; lines beyond this are dropped.
- FIFO_DEPTH, 4, output FIFO entries (power of 2).
- BYTE_SWAP, 0, 0: first byte of a pair is pixel[15:8]; 1: first byte is pixel[7:0].

Ports:
- clk100 in 1: system clock, 100 MHz.
- reset in 1: synchronous, active-high.
- cam_pclk in 1: camera pixel clock, asynchronous.
- cam_vsync in 1: camera frame sync, high during vertical blank.
- cam_href in 1: camera line valid.
- cam_data in 8: camera data.
- enable in 1: capture enable; sampled only at frame start.
- clear in 1: one-cycle pulse that clears the sticky flags.
- pix_data out 16: RGB565 pixel.
- pix_x out 10: pixel column.
- pix_y out 9: pixel row.
- pix_sof out 1: high for pixel (0,0).
- pix_valid out 1: stream valid.
- pix_ready in 1: stream ready.
- frame_done out 1: one-cycle pulse at frame end.
- frame_count out 8: completed frames, wraps.
- overflow out 1: sticky; a pixel was dropped because the FIFO was full.
- fmt_err out 1: sticky; odd byte count in a line, or line/frame exceeded H_ACTIVE/V_ACTIVE.

Behaviour:
- Synchronization:
  - pclk, vsync, href and data pass through 2-FF synchronizers, plus a third pclk stage.
  - pclk_rise = pclk_s2 & ~pclk_s3.
  - vsync, href and data are sampled from stage 2 only on pclk_rise (call these the sampled values).
- FSM states: IDLE, VBLANK, FRAME.
  - After reset: IDLE.
  - IDLE -> VBLANK when sampled vsync=1.
  - VBLANK -> FRAME when sampled vsync=0 and enable=1. On this transition, x/y/phase are cleared.
  - VBLANK with vsync=0 and enable=0 -> IDLE.
  - FRAME -> VBLANK when sampled vsync=1. On this transition, frame_done pulses and frame_count increments. This happens even if the frame was short.
- Byte packing (FRAME only, on pclk_rise with href=1):
  - phase=0: latch the byte, phase<=1.
  - phase=1: form the pixel, phase<=0.
- Line end (pclk_rise with href=0 while the previous sample had href=1):
  - If phase=1: set fmt_err and discard the half pixel.
  - Then x<=0, phase<=0, y<=y+1 (saturating at V_ACTIVE).
- Pixel push:
  - A pixel with x<H_ACTIVE and y<V_ACTIVE is written into the FIFO in the cycle it is formed, then x increments.
  - Otherwise the pixel is not written and fmt_err is set. x saturates at H_ACTIVE.
  - If the FIFO is full at write time: the pixel is dropped, overflow is set, and x still increments, so coordinates of later pixels stay correct.
- FIFO word: {sof, y, x, data} = 36 bits.
  - Write at cycle T gives pix_valid at T+1 when the FIFO was empty.
  - Read occurs when pix_valid & pix_ready.
  - Simultaneous read and write when full is not allowed: full is evaluated before the read, so the write is dropped.
  - Outputs stay stable while pix_valid=1 and pix_ready=0.
- Latency: cam_pclk pin edge to pix_valid = 5 clk100 cycles (2 sync + 1 edge + 1 pack/write + 1 FIFO).
- Sticky flags: overflow and fmt_err are cleared by reset or clear. If clear and a set condition happen in the same cycle, set wins.
- Reset values: every output is 0, the FIFO is empty, and the FSM is in IDLE. Reset mid-frame aborts the frame; capture resumes only after a full VBLANK.

Decomposition:
- Package cam_pkg holds:
  - the FSM state enum;
  - PIX_W=16, X_W=10, Y_W=9;
  - the FIFO word struct {sof, y, x, data}.
- One sub-module: cam_pix_fifo, a synchronous FIFO parameterised by width and depth with full/empty flags.

Test Plan:
- Basic frame: 4x2 frame (H_ACTIVE=4, V_ACTIVE=2), pclk = clk100/5, bytes 0x12,0x34,... with pix_ready=1 -> 8 pixels, first 0x1234 at (0,0) with sof=1, last at (3,1); frame_done fires once; frame_count=1.
- BYTE_SWAP=1, same bytes -> first pixel 0x3412.
- Backpressure: pix_ready=0 for a whole 640-pixel line -> exactly 4 pixels buffered, overflow=1; remaining pixels dropped with x still advancing; after clear, overflow=0.
- Odd-length line: 7 bytes -> 3 pixels, fmt_err=1, next line starts at x=0 with y+1.
- enable=0 during VBLANK -> no pixels and FSM returns to IDLE; set enable=1 -> next frame captured with frame_count=1.
- Reset asserted mid-line -> all outputs 0 next cycle; a frame that starts without a preceding VBLANK is ignored.
